// File: rtl/hub75_bcm_tx.sv
// HUB75 row driver: shifts one row per bit plane (LSB first), latches it, then lights it for a binary-weighted time.
// Latency per row = sum over planes of (1 + hpixel*(2*div+3) + div+1 + weight) cycles, then a DONE cycle; i_start is ignored while busy.
module hub75_bcm_tx #(
  parameter int hpixel_p   = 64,
  parameter int vpixel_p   = 64,
  parameter int bpp_p      = 8,
  parameter int segments_p = 2,
  localparam int rows_p    = vpixel_p / segments_p,
  localparam int rw_p      = $clog2(rows_p),
  localparam int aw_p      = $clog2(hpixel_p * rows_p),
  localparam int pw_p      = $clog2(bpp_p) + 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [3:0]                              i_clk_div,
  input  logic [7:0]                              i_oe_base,
  input  logic [pw_p-1:0]                         i_planes,
  input  logic                                    i_start,
  input  logic [rw_p-1:0]                         i_row,
  output logic                                    o_busy,
  output logic                                    o_done,
  output logic [aw_p-1:0]                         o_rd_addr,
  input  logic [segments_p-1:0][2:0][bpp_p-1:0]   i_rd_data,
  output logic                                    o_serial_clk,
  output logic [segments_p-1:0]                   o_red,
  output logic [segments_p-1:0]                   o_green,
  output logic [segments_p-1:0]                   o_blue,
  output logic                                    o_latch,
  output logic                                    o_oe_n,
  output logic [rw_p-1:0]                         o_row_addr
);

  localparam int cw_p = (hpixel_p > 1) ? $clog2(hpixel_p) : 1;
  localparam int bw_p = (bpp_p > 1) ? $clog2(bpp_p) : 1;
  localparam int tw_p = 8 + bpp_p;
  localparam logic [pw_p-1:0] bpp_c        = pw_p'(bpp_p);
  localparam logic [cw_p-1:0] col_last_c   = cw_p'(hpixel_p - 1);
  localparam logic [bw_p-1:0] plane_last_c = bw_p'(bpp_p - 1);
  localparam logic [aw_p-1:0] hpixel_c     = aw_p'(hpixel_p);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, LOW, HIGH, LATCH, SHOW, DONE} state_t;

  state_t            state_q, state_n;
  logic [rw_p-1:0]   row_q;
  logic [3:0]        div_q;
  logic [7:0]        oe_base_q;
  logic [bw_p-1:0]   first_q, b_q;
  logic [cw_p-1:0]   col_q;
  logic [tw_p-1:0]   cnt_q;

  logic [pw_p-1:0]   planes_c;
  logic [bw_p-1:0]   first_c;
  logic [tw_p-1:0]   weight;
  logic [aw_p-1:0]   row_base;
  logic              cnt_zero, last_col, last_plane, enter;

  assign cnt_zero   = (cnt_q == '0);
  assign last_col   = (col_q == col_last_c);
  assign last_plane = (b_q == plane_last_c);
  assign enter      = (state_n != state_q);

  always_comb begin
    planes_c = i_planes;
    if (i_planes == '0)
      planes_c = pw_p'(1);
    else if (i_planes > bpp_c)
      planes_c = bpp_c;
    first_c  = bw_p'(bpp_c - planes_c);
    weight   = tw_p'(oe_base_q) << (b_q - first_q);
    // The row is still on the input pins when leaving IDLE
    row_base = aw_p'((state_q == IDLE) ? i_row : row_q) * hpixel_c;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:  if (i_start) state_n = FETCH;
      FETCH: state_n = LOAD;
      LOAD:  state_n = LOW;
      LOW:   if (cnt_zero) state_n = HIGH;
      HIGH:  if (cnt_zero) state_n = last_col ? LATCH : LOAD;
      LATCH: if (cnt_zero) begin
               if (weight != '0)   state_n = SHOW;
               else if (last_plane) state_n = DONE;
               else                 state_n = FETCH;
             end
      SHOW:  if (cnt_zero) state_n = last_plane ? DONE : FETCH;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      div_q        <= '0;
      oe_base_q    <= '0;
      first_q      <= '0;
      b_q          <= '0;
      col_q        <= '0;
      cnt_q        <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_rd_addr    <= '0;
      o_serial_clk <= 1'b0;
      o_red        <= '0;
      o_green      <= '0;
      o_blue       <= '0;
      o_latch      <= 1'b0;
      o_oe_n       <= 1'b1;
      o_row_addr   <= '0;
    end else begin
      state_q      <= state_n;
      o_busy       <= (state_n != IDLE) && (state_n != DONE);
      o_done       <= (state_n == DONE);
      o_serial_clk <= (state_n == HIGH);
      o_latch      <= (state_n == LATCH);
      o_oe_n       <= (state_n != SHOW);

      if (state_q == IDLE && i_start) begin
        row_q     <= i_row;
        div_q     <= i_clk_div;
        oe_base_q <= i_oe_base;
        first_q   <= first_c;
        b_q       <= first_c;
      end

      if (enter && state_n == FETCH) begin
        o_rd_addr <= row_base;
        col_q     <= '0;
        if (state_q != IDLE)
          b_q <= b_q + bw_p'(1);
      end

      if (state_q == LOAD) begin
        for (int s = 0; s < segments_p; s++) begin
          o_red[s]   <= i_rd_data[s][2][b_q];
          o_green[s] <= i_rd_data[s][1][b_q];
          o_blue[s]  <= i_rd_data[s][0][b_q];
        end
      end

      // Prefetch the next pixel while the panel samples the current one
      if (state_q == LOW && state_n == HIGH && !last_col)
        o_rd_addr <= row_base + aw_p'(col_q) + aw_p'(1);

      if (state_q == HIGH && state_n == LOAD)
        col_q <= col_q + cw_p'(1);

      if (enter && state_n == LATCH) begin
        col_q      <= '0;
        o_row_addr <= row_q;
      end

      if (enter && (state_n == LOW || state_n == HIGH || state_n == LATCH))
        cnt_q <= tw_p'(div_q);
      else if (enter && state_n == SHOW)
        cnt_q <= weight - tw_p'(1);
      else if (!cnt_zero)
        cnt_q <= cnt_q - tw_p'(1);
    end
  end

endmodule
